// File: rtl/seg7_scan_reader_if.sv
// seg7_scan_reader_if -- signal bundle between a multiplexed 7-segment scan
// bus, the reader, and the downstream frame consumer.
//   seg7      : active-low segments, bit6=a .. bit0=g
//   dig_sel   : active-high digit select, legal when exactly one bit is set
//   out_ready : consumer accepts the held frame
//   out_valid : a captured frame is held on value/invalid/overrun
//   value     : decoded digits, digit0 in [3:0] .. digit3 in [15:12]
//   invalid   : per-digit flag, segment pattern not a hex glyph
//   overrun   : a complete frame was dropped while the held one waited
//   sync_err  : one-cycle pulse on a scan-order violation
interface seg7_scan_reader_if;
   logic [6:0]  seg7;
   logic [3:0]  dig_sel;
   logic        out_ready;
   logic        out_valid;
   logic [15:0] value;
   logic [3:0]  invalid;
   logic        overrun;
   logic        sync_err;

   modport master (
      output seg7, dig_sel, out_ready,
      input  out_valid, value, invalid, overrun, sync_err
   );

   modport slave (
      input  seg7, dig_sel, out_ready,
      output out_valid, value, invalid, overrun, sync_err
   );
endinterface

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader -- snoops a scanned 4-digit 7-segment display bus and
// reassembles complete digit0..digit3 frames into a 16-bit hex value with a
// valid/ready output handshake.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : seg7_scan_reader_if.slave (scan inputs, frame outputs, sync_err)
//
// state     | meaning
// WAIT_SYNC | no frame in progress, waiting for a digit-0 acceptance
// CAPTURE   | shadow frame in progress, expecting digit exp_idx
// OUTPUT    | frame held on outputs; shadow capture continues behind it
module seg7_scan_reader #(
   parameter int STABLE_CYCLES = 4
) (
   input logic               clk,
   input logic               reset,
   seg7_scan_reader_if.slave bus
);
   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {WAIT_SYNC, CAPTURE, OUTPUT} state_t;

   state_t      state, state_nxt;
   logic [6:0]  prev_seg;
   logic [3:0]  prev_sel;
   logic [3:0]  cnt, cnt_nxt;
   logic        armed;
   logic        one_hot, same, accept;
   logic [1:0]  idx;
   logic [3:0]  nib;
   logic        bad;

   logic [15:0] sh_val, sh_val_nxt;
   logic [3:0]  sh_inv, sh_inv_nxt;
   logic [1:0]  exp_idx, exp_nxt;
   logic        live, live_nxt;
   logic        frame_done, hs;
   logic        out_valid_nxt, overrun_nxt, sync_err_nxt;
   logic [15:0] value_nxt;
   logic [3:0]  invalid_nxt;

   always_comb begin
      one_hot = (bus.dig_sel != 4'd0) && ((bus.dig_sel & (bus.dig_sel - 4'd1)) == 4'd0);
      same    = (bus.dig_sel == prev_sel) && (bus.seg7 == prev_seg);
      if (one_hot && same) cnt_nxt = (cnt == STABLE) ? cnt : cnt + 4'd1;
      else                 cnt_nxt = one_hot ? 4'd1 : 4'd0;
      // armed drops on acceptance and returns only on a dig_sel change, so a
      // segment glitch within one selection cannot cause a second acceptance
      accept = armed && one_hot && (cnt_nxt == STABLE);
   end

   always_comb begin
      case (bus.dig_sel)
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

   always_comb begin
      bad = 1'b0;
      case (bus.seg7)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0000100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default: begin
            nib = 4'h0;
            bad = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_nxt     = state;
      sh_val_nxt    = sh_val;
      sh_inv_nxt    = sh_inv;
      exp_nxt       = exp_idx;
      live_nxt      = live;
      out_valid_nxt = bus.out_valid;
      value_nxt     = bus.value;
      invalid_nxt   = bus.invalid;
      overrun_nxt   = bus.overrun;
      sync_err_nxt  = 1'b0;
      frame_done    = 1'b0;
      hs            = bus.out_valid && bus.out_ready;

      // shadow capture runs identically in every state
      if (accept) begin
         if (idx == 2'd0) begin
            sh_val_nxt = {12'h000, nib};
            sh_inv_nxt = {3'b000, bad};
            exp_nxt    = 2'd1;
            live_nxt   = 1'b1;
         end else if (live && idx == exp_idx) begin
            sh_val_nxt[{idx, 2'b00} +: 4] = nib;
            sh_inv_nxt[idx]               = bad;
            exp_nxt                       = idx + 2'd1;
            if (idx == 2'd3) begin
               frame_done = 1'b1;
               live_nxt   = 1'b0;
            end
         end else if (live) begin
            sync_err_nxt = 1'b1;
            live_nxt     = 1'b0;
            sh_val_nxt   = 16'h0000;
            sh_inv_nxt   = 4'h0;
         end
      end

      case (state)
         WAIT_SYNC: begin
            if (live_nxt) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            if (frame_done) begin
               out_valid_nxt = 1'b1;
               value_nxt     = sh_val_nxt;
               invalid_nxt   = sh_inv_nxt;
               overrun_nxt   = 1'b0;
               state_nxt     = OUTPUT;
            end else if (!live_nxt) begin
               state_nxt = WAIT_SYNC;
            end
         end
         OUTPUT: begin
            if (frame_done) begin
               // a consumed held frame makes room for the new one in place
               if (hs) begin
                  value_nxt   = sh_val_nxt;
                  invalid_nxt = sh_inv_nxt;
                  overrun_nxt = 1'b0;
               end else begin
                  overrun_nxt = 1'b1;
               end
            end else if (hs) begin
               out_valid_nxt = 1'b0;
               overrun_nxt   = 1'b0;
               state_nxt     = live_nxt ? CAPTURE : WAIT_SYNC;
            end
         end
         default: state_nxt = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= WAIT_SYNC;
         prev_seg      <= 7'h7F;
         prev_sel      <= 4'h0;
         cnt           <= 4'h0;
         armed         <= 1'b1;
         sh_val        <= 16'h0000;
         sh_inv        <= 4'h0;
         exp_idx       <= 2'd0;
         live          <= 1'b0;
         bus.out_valid <= 1'b0;
         bus.value     <= 16'h0000;
         bus.invalid   <= 4'h0;
         bus.overrun   <= 1'b0;
         bus.sync_err  <= 1'b0;
      end else begin
         state         <= state_nxt;
         prev_seg      <= bus.seg7;
         prev_sel      <= bus.dig_sel;
         cnt           <= cnt_nxt;
         if (bus.dig_sel != prev_sel) armed <= 1'b1;
         else if (accept)             armed <= 1'b0;
         sh_val        <= sh_val_nxt;
         sh_inv        <= sh_inv_nxt;
         exp_idx       <= exp_nxt;
         live          <= live_nxt;
         bus.out_valid <= out_valid_nxt;
         bus.value     <= value_nxt;
         bus.invalid   <= invalid_nxt;
         bus.overrun   <= overrun_nxt;
         bus.sync_err  <= sync_err_nxt;
      end
   end
endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_reader_if bus ();

   seg7_scan_reader #(.STABLE_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [15:0] value;
      logic [3:0]  invalid;
      logic        overrun;
   } frame_t;

   frame_t exp_q[$];
   int tests = 0;
   int fails = 0;
   int valid_cycles = 0;
   int err_seen = 0;
   int v0, e0;

   logic [6:0] seg_lut [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
   };

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // drives one selection for n sampling edges, returning 2 ns after the last
   task automatic hold(input logic [3:0] sel, input logic [6:0] seg, input int n);
      bus.dig_sel = sel;
      bus.seg7    = seg;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic show_digit(input int pos, input logic [3:0] hex, input int n);
      hold(4'b0001 << pos, seg_lut[hex], n);
   endtask

   task automatic frame(input logic [15:0] v, input int n);
      for (int i = 0; i < 4; i++) show_digit(i, v[4*i +: 4], n);
   endtask

   task automatic push(input logic [15:0] v, input logic [3:0] inv, input logic ovr);
      frame_t f;
      f.value = v; f.invalid = inv; f.overrun = ovr;
      exp_q.push_back(f);
   endtask

   // scoreboard: every handshake pops and compares the oldest expected frame
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.sync_err) err_seen++;
         if (bus.out_valid) valid_cycles++;
         if (bus.out_valid && bus.out_ready) begin
            check("frame_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               frame_t f;
               f = exp_q.pop_front();
               check("frame_value", bus.value, f.value);
               check("frame_invalid", bus.invalid, f.invalid);
               check("frame_overrun", bus.overrun, f.overrun);
            end
         end
      end
   end

   initial begin
      bus.dig_sel   = 4'h0;
      bus.seg7      = 7'h7F;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_value", bus.value, 0);
      check("rst_invalid", bus.invalid, 0);
      check("rst_overrun", bus.overrun, 0);
      check("rst_sync_err", bus.sync_err, 0);
      #1 reset = 1'b0;

      // basic frame C,d,E,F with consumer always ready
      bus.out_ready = 1'b1;
      push(16'hFEDC, 4'h0, 1'b0);
      v0 = valid_cycles; e0 = err_seen;
      show_digit(0, 4'hC, 6);
      show_digit(1, 4'hD, 6);
      show_digit(2, 4'hE, 6);
      show_digit(3, 4'hF, 3);
      check("lat_before_accept", bus.out_valid, 0);
      show_digit(3, 4'hF, 1);
      check("lat_after_accept", bus.out_valid, 1);
      check("lat_value", bus.value, 16'hFEDC);
      show_digit(3, 4'hF, 2);
      check("valid_one_cycle", valid_cycles - v0, 1);
      check("no_sync_err", err_seen - e0, 0);

      // digit 1 too short: digit 2 arrives out of order
      v0 = valid_cycles; e0 = err_seen;
      show_digit(0, 4'h1, 6);
      show_digit(1, 4'h2, 3);
      show_digit(2, 4'h3, 6);
      check("short_digit_sync_err", err_seen - e0, 1);
      show_digit(3, 4'h4, 6);
      check("short_digit_no_frame", valid_cycles - v0, 0);

      // undecodable digit 2 with blanking between digits
      push(16'h3021, 4'b0100, 1'b0);
      show_digit(0, 4'h1, 6);
      hold(4'h0, 7'h7F, 2);
      show_digit(1, 4'h2, 6);
      hold(4'b0100, 7'b1111111, 6);
      show_digit(3, 4'h3, 6);

      // two frames with the consumer stalled
      bus.out_ready = 1'b0;
      push(16'h4321, 4'h0, 1'b1);
      frame(16'h4321, 6);
      frame(16'h8765, 6);
      check("stall_valid", bus.out_valid, 1);
      check("stall_value", bus.value, 16'h4321);
      check("stall_overrun", bus.overrun, 1);
      bus.out_ready = 1'b1;
      hold(4'h0, 7'h7F, 1);
      bus.out_ready = 1'b0;
      check("stall_valid_after_hs", bus.out_valid, 0);

      // handshake in the same cycle a new frame completes
      push(16'h3210, 4'h0, 1'b0);
      push(16'h6789, 4'h0, 1'b0);
      frame(16'h3210, 6);
      show_digit(0, 4'h9, 6);
      show_digit(1, 4'h8, 6);
      show_digit(2, 4'h7, 6);
      show_digit(3, 4'h6, 3);
      check("coinc_valid_pre", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      show_digit(3, 4'h6, 1);
      bus.out_ready = 1'b0;
      check("coinc_valid", bus.out_valid, 1);
      check("coinc_value", bus.value, 16'h6789);
      check("coinc_overrun", bus.overrun, 0);
      show_digit(3, 4'h6, 2);
      bus.out_ready = 1'b1;
      hold(4'h0, 7'h7F, 1);
      bus.out_ready = 1'b0;
      check("coinc_valid_after_hs", bus.out_valid, 0);

      // reset while a frame is held and another is half captured
      show_digit(0, 4'h5, 6);
      hold(4'b0010, 7'b1111110, 6);
      show_digit(2, 4'hA, 6);
      show_digit(3, 4'hB, 6);
      check("pre_rst_valid", bus.out_valid, 1);
      check("pre_rst_invalid", bus.invalid, 4'b0010);
      show_digit(0, 4'h1, 6);
      show_digit(1, 4'h2, 6);
      #1 reset = 1'b1;
      #1;
      check("async_rst_valid", bus.out_valid, 0);
      check("async_rst_value", bus.value, 0);
      check("async_rst_invalid", bus.invalid, 0);
      check("async_rst_overrun", bus.overrun, 0);
      check("async_rst_sync_err", bus.sync_err, 0);
      @(posedge clk);
      #2 reset = 1'b0;
      v0 = valid_cycles; e0 = err_seen;
      bus.out_ready = 1'b1;
      show_digit(1, 4'h3, 6);
      show_digit(2, 4'h4, 6);
      show_digit(3, 4'h5, 6);
      check("post_rst_no_frame", valid_cycles - v0, 0);
      check("post_rst_no_err", err_seen - e0, 0);
      hold(4'h0, 7'h7F, 2);

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seg7_scan_reader.md
SEG7_SCAN_READER -- requirements
Module: seg7_scan_reader

Interface
REQ-001 The module SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 The module SHALL have one parameter: STABLE_CYCLES, default 4, the number of consecutive identical samples required to accept a digit (legal range 2..15).
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port seg7, input, 7 bits: active-low segments, bit6=a through bit0=g.
REQ-006 Port dig_sel, input, 4 bits: active-high digit select from the scanning display driver; a legal selection is exactly one bit set.
REQ-007 Port out_ready, input, 1 bit: downstream accepts the frame when high together with out_valid.
REQ-008 Port out_valid, output, 1 bit: a captured frame is held on value, invalid and overrun.
REQ-009 Port value, output, 16 bits: decoded hex digits, with digit0 in [3:0] through digit3 in [15:12].
REQ-010 Port invalid, output, 4 bits: per digit, the pattern was not in the decode table.
REQ-011 Port overrun, output, 1 bit: at least one complete frame was discarded while this frame waited.
REQ-012 Port sync_err, output, 1 bit: one-cycle pulse on a scan-order violation.

Function
REQ-013 Decode table for seg7 to nibble SHALL be:
- 0000001=0, 1001111=1, 0010010=2, 0000110=3
- 1001100=4, 0100100=5, 0100000=6, 0001111=7
- 0000000=8, 0000100=9, 0001000=A, 1100000=b
- 0110001=C, 1000010=d, 0110000=E, 0111000=F
- Any other pattern: nibble 0, invalid bit set.
REQ-014 Stability counter SHALL increment while dig_sel and seg7 equal their previous-cycle values and dig_sel is one-hot; otherwise it SHALL reload to 1 (one-hot) or 0 (not one-hot), and it SHALL saturate at STABLE_CYCLES.
REQ-015 A digit SHALL be accepted in the cycle the counter reaches STABLE_CYCLES; at most one acceptance SHALL occur per continuous selection period, re-armed only when dig_sel changes.
REQ-016 FSM states SHALL be WAIT_SYNC, CAPTURE and OUTPUT.
REQ-017 In WAIT_SYNC, acceptance of digit 0 (dig_sel=0001) SHALL store digit0 and move to CAPTURE with expected index 1; acceptances of other digits SHALL be ignored.
REQ-018 In CAPTURE, acceptance of the expected index SHALL store it into the shadow register and advance the index.
REQ-019 In CAPTURE, acceptance of any other index SHALL pulse sync_err for one cycle, discard the shadow, and return to WAIT_SYNC; if that index is 0, it SHALL instead restart the frame with digit0 stored and no error.
REQ-020 On acceptance of digit 3, the shadow SHALL be copied to value/invalid and out_valid SHALL rise the next cycle (1-cycle latency), with state OUTPUT.
REQ-021 In OUTPUT, out_valid, value, invalid and overrun SHALL hold stable until out_valid and out_ready are both high in a cycle; out_valid SHALL fall the following cycle.
REQ-022 Capture into the shadow SHALL continue in OUTPUT.
REQ-023 In OUTPUT, a shadow frame completing while the held frame is unaccepted SHALL be discarded and overrun SHALL be set.
REQ-024 If the handshake and a shadow completion occur in the same cycle, the new frame SHALL be loaded (overrun=0) and out_valid SHALL remain high.
REQ-025 After the handshake with no pending frame, the FSM SHALL go to CAPTURE if a shadow frame is in progress, else to WAIT_SYNC.
REQ-026 Blanking (dig_sel=0000) SHALL NOT abort a frame; it only resets the stability counter.

Reset
REQ-027 Asserting reset SHALL immediately force: out_valid=0, value=0000, invalid=0000, overrun=0, sync_err=0, state WAIT_SYNC, counter 0, shadow cleared.
REQ-028 Reset mid-frame or during OUTPUT SHALL discard all data; after release, capture SHALL begin only with a fresh digit-0 acceptance.

Verification
REQ-029 Scan C,d,E,F on digits 0..3, each held 6 cycles, with out_ready=1 -> value=FEDC, invalid=0000, out_valid high for exactly 1 cycle, 1 cycle after digit-3 acceptance.
REQ-030 Digit 1 held only STABLE_CYCLES-1 cycles, then digit 2 -> no acceptance of digit 1, sync_err pulse on digit-2 acceptance, state WAIT_SYNC.
REQ-031 Digit 2 pattern 1111111 in an otherwise valid frame -> value[11:8]=0, invalid=0100.
REQ-032 out_ready=0 across two complete frames (1234, then 5678) -> value stays 4321, overrun=1; after the handshake, out_valid=0.
REQ-033 Handshake coincident with a frame completing -> new value loaded, overrun=0, out_valid continuous.
REQ-034 Reset pulsed mid-frame after digits 0-1 -> all outputs 0 immediately; a frame after release without digit 0 produces no out_valid.
